// File: rtl/text_ram_writer.sv
// Write-side companion of the VGA label RAM: turns a valid/ready ASCII stream into
// single-cycle RAM writes inside a rectangular text region, gated by the blanking window.
module text_ram_writer #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned LINE_LEN   = 16,
  parameter int unsigned NUM_LINES  = 4
) (
  input  logic                  px_clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  wr_allow,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_din,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] cursor,
  output logic                  busy
);

  localparam int unsigned Region = LINE_LEN * NUM_LINES;
  localparam int unsigned ColW   = $clog2(LINE_LEN);
  localparam int unsigned RowW   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int unsigned ClrW   = $clog2(Region);

  localparam logic [ColW-1:0]       LastCol = ColW'(LINE_LEN - 1);
  localparam logic [RowW-1:0]       LastRow = RowW'(NUM_LINES - 1);
  localparam logic [ClrW-1:0]       LastClr = ClrW'(Region - 1);
  localparam logic [ADDR_WIDTH-1:0] BaseA   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LineA   = ADDR_WIDTH'(LINE_LEN);

  typedef enum logic [1:0] {StIdle, StExec, StClear} stateT;

  stateT           stateQ, stateD;
  logic [RowW-1:0] rowQ, rowD, rowNext;
  logic [ColW-1:0] colQ, colD;
  logic [ClrW-1:0] clrPtrQ, clrPtrD;
  logic [7:0]      byteQ, byteD;

  logic                  weD;
  logic [ADDR_WIDTH-1:0] addrD;
  logic [7:0]            dinD;
  logic                  accept;
  logic                  isPrint;

  function automatic logic [ADDR_WIDTH-1:0] cellAddr(input logic [RowW-1:0] r,
                                                     input logic [ColW-1:0] c);
    return BaseA + ADDR_WIDTH'(r) * LineA + ADDR_WIDTH'(c);
  endfunction

  assign accept  = in_valid && in_ready;
  assign isPrint = (byteQ >= 8'h20) && (byteQ <= 8'h7E);
  assign rowNext = (rowQ == LastRow) ? '0 : rowQ + RowW'(1);

  // State and cursor registers
  always_ff @(posedge px_clk) begin
    if (rst) begin
      stateQ  <= StIdle;
      rowQ    <= '0;
      colQ    <= '0;
      clrPtrQ <= '0;
      byteQ   <= '0;
    end else begin
      stateQ  <= stateD;
      rowQ    <= rowD;
      colQ    <= colD;
      clrPtrQ <= clrPtrD;
      byteQ   <= byteD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD  = stateQ;
    rowD    = rowQ;
    colD    = colQ;
    clrPtrD = clrPtrQ;
    byteD   = byteQ;
    unique case (stateQ)
      StIdle: begin
        if (accept) begin
          byteD  = in_data;
          stateD = StExec;
        end
      end
      StExec: begin
        stateD = StIdle;
        if (isPrint) begin
          if (!wr_allow) begin
            stateD = StExec;
          end else if (colQ == LastCol) begin
            colD = '0;
            rowD = rowNext;
          end else begin
            colD = colQ + ColW'(1);
          end
        end else begin
          case (byteQ)
            8'h0D: colD = '0;
            8'h0A: begin
              colD = '0;
              rowD = rowNext;
            end
            8'h08: begin
              // Backspace stops at the first cell of the region and never erases.
              if (rowQ != '0 || colQ != '0) begin
                if (colQ == '0) begin
                  colD = LastCol;
                  rowD = rowQ - RowW'(1);
                end else begin
                  colD = colQ - ColW'(1);
                end
              end
            end
            8'h0C: begin
              clrPtrD = '0;
              stateD  = StClear;
            end
            default: ;
          endcase
        end
      end
      StClear: begin
        if (wr_allow) begin
          if (clrPtrQ == LastClr) begin
            rowD   = '0;
            colD   = '0;
            stateD = StIdle;
          end else begin
            clrPtrD = clrPtrQ + ClrW'(1);
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Write-port drive; address and data stay zero when not writing so the bus can be OR-ed.
  always_comb begin
    weD   = 1'b0;
    addrD = '0;
    dinD  = '0;
    unique case (stateQ)
      StExec: begin
        if (isPrint && wr_allow) begin
          weD   = 1'b1;
          addrD = cellAddr(rowQ, colQ);
          dinD  = byteQ;
        end
      end
      StClear: begin
        if (wr_allow) begin
          weD   = 1'b1;
          addrD = BaseA + ADDR_WIDTH'(clrPtrQ);
          dinD  = 8'h20;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      cursor   <= BaseA;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      ram_we   <= weD;
      ram_addr <= addrD;
      ram_din  <= dinD;
      cursor   <= cellAddr(rowD, colD);
      busy     <= (stateD != StIdle);
      in_ready <= (stateD == StIdle);
    end
  end

endmodule
